vga_scan_timing: RTL and testbench

//  Scan-side partner of the frame buffer controller. Generates the raster counter_H/counter_V that the

---
 rtl/vga_scan_timing.sv | 111 +++++++++++
 tb/tb_vga_scan_timing.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timing.sv
// Raster scan generator: column/line counters for the frame buffer controller, plus sync and
// blanking delayed to meet the controller's pipelined colour.
module vga_scan_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       colour_in,
    output logic [9:0] counter_H,
    output logic [9:0] counter_V,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit bounds so a sum that reaches 1024 still compares correctly
    localparam logic [10:0] H_VIS_END = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYN_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYN_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYN_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYN_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } tim_t;

    localparam tim_t C_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

    logic [9:0]               r_cnt_h;
    logic [9:0]               r_cnt_v;
    tim_t [PIPE_LAT:0]        r_dly;
    logic                     r_pixel;
    logic                     r_line_start;
    logic                     r_frame_start;

    logic                     w_h_wrap;
    logic                     w_v_wrap;
    tim_t                     w_raw;
    tim_t [PIPE_LAT+1:0]      w_chain;
    logic [10:0]              w_h11;
    logic [10:0]              w_v11;

    assign w_h11    = {1'b0, r_cnt_h};
    assign w_v11    = {1'b0, r_cnt_v};
    assign w_h_wrap = (r_cnt_h == H_LAST);
    assign w_v_wrap = (r_cnt_v == V_LAST);

    assign w_raw.hs  = !((w_h11 >= H_SYN_BEG) && (w_h11 < H_SYN_END));
    assign w_raw.vs  = !((w_v11 >= V_SYN_BEG) && (w_v11 < V_SYN_END));
    assign w_raw.vis = (w_h11 < H_VIS_END) && (w_v11 < V_VIS_END);

    // w_chain[0] is the raw timing, w_chain[k+1] the k-th delay stage
    assign w_chain = {r_dly, w_raw};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt_h       <= '0;
            r_cnt_v       <= '0;
            r_dly         <= {(PIPE_LAT+1){C_IDLE}};
            r_pixel       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_en) begin
                if (w_h_wrap) begin
                    r_cnt_h <= '0;
                    r_cnt_v <= w_v_wrap ? 10'd0 : r_cnt_v + 10'd1;
                end else begin
                    r_cnt_h <= r_cnt_h + 10'd1;
                end
                r_dly         <= w_chain[PIPE_LAT:0];
                // gate with the stage about to become the output so pixel and video_on stay paired
                r_pixel       <= colour_in & w_chain[PIPE_LAT].vis;
                r_line_start  <= w_h_wrap;
                r_frame_start <= w_h_wrap & w_v_wrap;
            end
        end
    end

    assign counter_H   = r_cnt_h;
    assign counter_V   = r_cnt_v;
    assign hsync       = w_chain[PIPE_LAT+1].hs;
    assign vsync       = w_chain[PIPE_LAT+1].vs;
    assign video_on    = w_chain[PIPE_LAT+1].vis;
    assign pixel       = r_pixel;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench: a default 640x480 instance plus a tiny zero-latency instance that can run whole frames.
module tb_vga_scan_timing;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pix;
        logic       ls;
        logic       fs;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, pe0, col0, rst1, pe1, col1;
    logic [9:0] h0, v0, h1, v1;
    logic       hs0, vs0, von0, pix0, ls0, fs0;
    logic       hs1, vs1, von1, pix1, ls1, fs1;
    out_t       act0, act1;

    assign act0 = {h0, v0, hs0, vs0, von0, pix0, ls0, fs0};
    assign act1 = {h1, v1, hs1, vs1, von1, pix1, ls1, fs1};

    vga_scan_timing u_dut0 (
        .clk(clk), .reset(rst0), .pix_en(pe0), .colour_in(col0),
        .counter_H(h0), .counter_V(v0), .hsync(hs0), .vsync(vs0), .video_on(von0),
        .pixel(pix0), .line_start(ls0), .frame_start(fs0)
    );

    vga_scan_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_LAT(0)
    ) u_dut1 (
        .clk(clk), .reset(rst1), .pix_en(pe1), .colour_in(col1),
        .counter_H(h1), .counter_V(v1), .hsync(hs1), .vsync(vs1), .video_on(von1),
        .pixel(pix1), .line_start(ls1), .frame_start(fs1)
    );

    int P_HA[2]  = '{640, 8};
    int P_HF[2]  = '{16, 2};
    int P_HS[2]  = '{96, 3};
    int P_HB[2]  = '{48, 3};
    int P_VA[2]  = '{480, 4};
    int P_VF[2]  = '{10, 1};
    int P_VS[2]  = '{2, 2};
    int P_VB[2]  = '{33, 1};
    int P_LAT[2] = '{3, 0};

    int n_chk  = 0;
    int n_fail = 0;

    out_t sbq0[$];
    out_t sbq1[$];

    // reference model state
    int         mh[2];
    int         mv[2];
    logic [2:0] hist[2][0:7];
    out_t       last[2];

    // observed-output statistics
    int   cnt_ls0, cnt_fs0, cnt_hs0, cnt_von0, cnt_pix0, fall_von_h, fall_hs_h;
    logic prev_von0, prev_hs0;
    int   cnt_fs1 = 0;
    int   cnt_vs1 = 0;
    out_t e0, e1;
    int   cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input out_t a, input out_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b von=%b pix=%b ls=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b von=%b pix=%b ls=%b fs=%b",
                     name, $time, a.h, a.v, a.hs, a.vs, a.von, a.pix, a.ls, a.fs,
                     e.h, e.v, e.hs, e.vs, e.von, e.pix, e.ls, e.fs);
        end
    endtask

    function automatic logic [2:0] raw_of(input int k, input int h, input int v);
        logic hs, vs, vis;
        hs  = !(h >= P_HA[k] + P_HF[k] && h < P_HA[k] + P_HF[k] + P_HS[k]);
        vs  = !(v >= P_VA[k] + P_VF[k] && v < P_VA[k] + P_VF[k] + P_VS[k]);
        vis = (h < P_HA[k]) && (v < P_VA[k]);
        return {hs, vs, vis};
    endfunction

    task automatic model_step(input int k, input logic rst, input logic pe, input logic col);
        out_t e;
        int   ht, vt;
        ht = P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k];
        vt = P_VA[k] + P_VF[k] + P_VS[k] + P_VB[k];
        e = last[k];
        e.ls = 1'b0;
        e.fs = 1'b0;
        if (!rst) begin
            mh[k] = 0;
            mv[k] = 0;
            for (int i = 0; i < 8; i++) hist[k][i] = 3'b110;
            e = '0;
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else if (pe) begin
            for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = raw_of(k, mh[k], mv[k]);
            {e.hs, e.vs, e.von} = hist[k][P_LAT[k]];
            e.pix = col & e.von;
            e.ls  = (mh[k] == ht - 1);
            e.fs  = e.ls && (mv[k] == vt - 1);
            if (mh[k] == ht - 1) begin
                mh[k] = 0;
                mv[k] = (mv[k] == vt - 1) ? 0 : mv[k] + 1;
            end else begin
                mh[k] = mh[k] + 1;
            end
        end
        e.h = 10'(mh[k]);
        e.v = 10'(mv[k]);
        last[k] = e;
        if (k == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endtask

    task automatic clear_stats0();
        cnt_ls0 = 0; cnt_fs0 = 0; cnt_hs0 = 0; cnt_von0 = 0; cnt_pix0 = 0;
        fall_von_h = -1; fall_hs_h = -1;
        prev_von0 = 1'b0; prev_hs0 = 1'b1;
    endtask

    // monitor: one expected entry per clock per instance
    always @(posedge clk) begin
        #1;
        if (sbq0.size() > 0) begin
            e0 = sbq0.pop_front();
            chk_out("scan0", act0, e0);
            if (ls0)   cnt_ls0++;
            if (fs0)   cnt_fs0++;
            if (!hs0)  cnt_hs0++;
            if (von0)  cnt_von0++;
            if (pix0)  cnt_pix0++;
            if (prev_von0 && !von0) fall_von_h = int'(h0);
            if (prev_hs0 && !hs0)   fall_hs_h  = int'(h0);
            prev_von0 = von0;
            prev_hs0  = hs0;
        end
        if (sbq1.size() > 0) begin
            e1 = sbq1.pop_front();
            chk_out("scan1", act1, e1);
            if (fs1)  cnt_fs1++;
            if (!vs1) cnt_vs1++;
        end
    end

    task automatic tick(input logic r0, input logic p0, input logic c0);
        @(negedge clk);
        if (cyc == 260) begin
            check("small frame_start pulses", cnt_fs1, 2);
            check("small vsync low ticks", cnt_vs1, 64);
        end
        rst0 = r0; pe0 = p0; col0 = c0;
        rst1 = (cyc >= 2);
        pe1  = (cyc < 260) ? 1'b1 : 1'($urandom_range(0, 1));
        col1 = 1'($urandom_range(0, 1));
        model_step(0, rst0, pe0, col0);
        model_step(1, rst1, pe1, col1);
        cyc++;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst0 = 1'b0; pe0 = 1'b1; col0 = 1'b0;
        rst1 = 1'b0; pe1 = 1'b1; col1 = 1'b0;
        clear_stats0();

        // reset held three clocks with pix_en high
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        settle();
        check("reset counter_H", int'(h0), 0);
        check("reset counter_V", int'(v0), 0);
        clear_stats0();

        // one full line with white colour
        repeat (800) tick(1'b1, 1'b1, 1'b1);
        settle();
        check("line wrap counter_H", int'(h0), 0);
        check("line wrap counter_V", int'(v0), 1);
        check("line_start pulses", cnt_ls0, 1);
        check("frame_start pulses", cnt_fs0, 0);
        check("hsync low ticks", cnt_hs0, 96);
        check("video_on ticks", cnt_von0, 640);
        check("pixel high ticks", cnt_pix0, 640);
        check("video_on fall at counter_H", fall_von_h, 644);
        check("hsync fall at counter_H", fall_hs_h, 660);

        // pix_en alternating to reach (300,2)
        repeat (1100) begin
            tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            tick(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        end
        settle();
        check("toggled counter_H", int'(h0), 300);
        check("toggled counter_V", int'(v0), 2);

        // mid-frame reset with pix_en low, then restart
        tick(1'b0, 1'b0, 1'b1);
        repeat (10) tick(1'b1, 1'b1, 1'b1);
        settle();
        check("restart counter_H", int'(h0), 10);
        check("restart counter_V", int'(v0), 0);

        settle();
        check("scoreboard0 drained", sbq0.size(), 0);
        check("scoreboard1 drained", sbq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
